// File: rtl/fx_arb.sv
// fx_arb: two-requester arbiter and sequencer for the shared 8-bit fx register bus.
// Build option FX_ARB_RR_EN selects round-robin arbitration; otherwise m0 has fixed priority.
module fx_arb #(
    parameter int RD_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [21:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic        m0_ack,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [21:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic        m1_ack,
    output logic [7:0]  m1_rdata,
    output logic        fx_wr,
    output logic        fx_rd,
    output logic [21:0] fx_waddr,
    output logic [21:0] fx_raddr,
    output logic [7:0]  fx_data,
    input  logic [7:0]  fx_q,
    output logic        busy,
    output logic [1:0]  gnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t      state_q;
    logic [1:0]  gnt_q;
    logic        isWrite_q;
    logic [2:0]  latCnt_q;
    logic        fxWr_q;
    logic        fxRd_q;
    logic [21:0] fxWaddr_q;
    logic [21:0] fxRaddr_q;
    logic [7:0]  fxData_q;
    logic        m0Ack_q;
    logic        m1Ack_q;
    logic [7:0]  m0Rdata_q;
    logic [7:0]  m1Rdata_q;
    logic        busy_q;
`ifdef FX_ARB_RR_EN
    logic        lastM1_q;
`endif

    logic [1:0]  win_d;
    logic        selWr;
    logic [21:0] selAddr;
    logic [7:0]  selWdata;

    // Winner selection and mux of the winning requester's command fields.
    always_comb begin
        win_d = 2'b00;
        if (m0_req && m1_req) begin
`ifdef FX_ARB_RR_EN
            win_d = lastM1_q ? 2'b01 : 2'b10;
`else
            win_d = 2'b01;
`endif
        end else if (m0_req) begin
            win_d = 2'b01;
        end else if (m1_req) begin
            win_d = 2'b10;
        end
        selWr    = win_d[1] ? m1_wr    : m0_wr;
        selAddr  = win_d[1] ? m1_addr  : m0_addr;
        selWdata = win_d[1] ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            isWrite_q <= 1'b0;
            latCnt_q  <= 3'd0;
            fxWr_q    <= 1'b0;
            fxRd_q    <= 1'b0;
            fxWaddr_q <= 22'd0;
            fxRaddr_q <= 22'd0;
            fxData_q  <= 8'd0;
            m0Ack_q   <= 1'b0;
            m1Ack_q   <= 1'b0;
            m0Rdata_q <= 8'd0;
            m1Rdata_q <= 8'd0;
            busy_q    <= 1'b0;
`ifdef FX_ARB_RR_EN
            lastM1_q  <= 1'b1;
`endif
        end else begin
            fxWr_q  <= 1'b0;
            fxRd_q  <= 1'b0;
            m0Ack_q <= 1'b0;
            m1Ack_q <= 1'b0;
            case (state_q)
                // The strobe for the ISSUE cycle is set up here so it leaves a register.
                IDLE: begin
                    if (win_d != 2'b00) begin
                        gnt_q     <= win_d;
                        busy_q    <= 1'b1;
                        isWrite_q <= selWr;
                        fxWr_q    <= selWr;
                        fxRd_q    <= ~selWr;
                        if (selWr) begin
                            fxWaddr_q <= selAddr;
                            fxData_q  <= selWdata;
                        end else begin
                            fxRaddr_q <= selAddr;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (isWrite_q) begin
                        m0Ack_q <= gnt_q[0];
                        m1Ack_q <= gnt_q[1];
                        state_q <= DONE;
                    end else begin
                        latCnt_q <= LAT_LAST;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (latCnt_q == 3'd0) begin
                        if (gnt_q[0]) m0Rdata_q <= fx_q;
                        if (gnt_q[1]) m1Rdata_q <= fx_q;
                        m0Ack_q <= gnt_q[0];
                        m1Ack_q <= gnt_q[1];
                        state_q <= DONE;
                    end else begin
                        latCnt_q <= latCnt_q - 3'd1;
                    end
                end
                DONE: begin
`ifdef FX_ARB_RR_EN
                    lastM1_q <= gnt_q[1];
`endif
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fx_wr    = fxWr_q;
    assign fx_rd    = fxRd_q;
    assign fx_waddr = fxWaddr_q;
    assign fx_raddr = fxRaddr_q;
    assign fx_data  = fxData_q;
    assign m0_ack   = m0Ack_q;
    assign m1_ack   = m1Ack_q;
    assign m0_rdata = m0Rdata_q;
    assign m1_rdata = m1Rdata_q;
    assign busy     = busy_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_fx_arb.sv
// Bench for fx_arb: a directed vector table, hand-written multi-cycle sequences, and
// randomized traffic checked against a transaction-level timing model.
module tb_fx_arb;
    localparam int RD_LAT = 1;
    localparam int NTXN   = 1000;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [21:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata, fx_q;
    logic        m0_ack, m1_ack, fx_wr, fx_rd, busy;
    logic [7:0]  m0_rdata, m1_rdata, fx_data;
    logic [21:0] fx_waddr, fx_raddr;
    logic [1:0]  gnt;

    logic        t3Req, t3Wr, t3M1Req, t3M1Wr;
    logic [21:0] t3Addr, t3M1Addr;
    logic [7:0]  t3Wdata, t3M1Wdata, t3FxQ;
    logic        t3M0Ack, t3M1Ack, t3FxWr, t3FxRd, t3Busy;
    logic [7:0]  t3M0Rdata, t3M1Rdata, t3Data;
    logic [21:0] t3Waddr, t3Raddr;
    logic [1:0]  t3Gnt;

    fx_arb #(.RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .fx_wr(fx_wr), .fx_rd(fx_rd), .fx_waddr(fx_waddr), .fx_raddr(fx_raddr),
        .fx_data(fx_data), .fx_q(fx_q), .busy(busy), .gnt(gnt)
    );

    fx_arb #(.RD_LAT(3)) dut3 (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(t3Req), .m0_wr(t3Wr), .m0_addr(t3Addr), .m0_wdata(t3Wdata),
        .m0_ack(t3M0Ack), .m0_rdata(t3M0Rdata),
        .m1_req(t3M1Req), .m1_wr(t3M1Wr), .m1_addr(t3M1Addr), .m1_wdata(t3M1Wdata),
        .m1_ack(t3M1Ack), .m1_rdata(t3M1Rdata),
        .fx_wr(t3FxWr), .fx_rd(t3FxRd), .fx_waddr(t3Waddr), .fx_raddr(t3Raddr),
        .fx_data(t3Data), .fx_q(t3FxQ), .busy(t3Busy), .gnt(t3Gnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        m0Req, m0Wr;
        logic [21:0] m0Addr;
        logic [7:0]  m0Wdata;
        logic        m1Req, m1Wr;
        logic [21:0] m1Addr;
        logic [7:0]  m1Wdata;
        logic [7:0]  fxQ;
        logic [95:0] expOut;
    } vec_t;

    vec_t vecs[13];
    int   assertCount;
    int   failCount;

    // Random-run model state
    logic        pend[2];
    logic        pWr[2];
    logic [21:0] pAddr[2];
    logic [7:0]  pData[2];
    logic        justAcked[2];
    int          issued[2];
    int          dutAcks[2];
    int          issuedTotal, doneCount, cyc, freeCyc, sCyc, aCyc, capCyc;
    int          mOwner, lastServed;
    bit          mBusy, tWr;
    logic [21:0] tAddr;
    logic [7:0]  tData, capData;
    logic [1:0]  expGnt;
    bit          inRange;
    int          order[$];
    int          nWant, budget;

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [95:0] actualOut();
        return {21'd0, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, m0_ack, m1_ack,
                m0_rdata, m1_rdata, busy, gnt};
    endfunction

    function automatic vec_t mkVec(
        input logic m0Req, input logic m0Wr, input logic [21:0] m0Addr, input logic [7:0] m0Wdata,
        input logic m1Req, input logic m1Wr, input logic [21:0] m1Addr, input logic [7:0] m1Wdata,
        input logic [7:0] fxQ,
        input logic eWr, input logic eRd, input logic [21:0] eWaddr, input logic [21:0] eRaddr,
        input logic [7:0] eData, input logic eAck0, input logic eAck1,
        input logic [7:0] eRd0, input logic [7:0] eRd1, input logic eBusy, input logic [1:0] eGnt);
        vec_t v;
        v.m0Req = m0Req; v.m0Wr = m0Wr; v.m0Addr = m0Addr; v.m0Wdata = m0Wdata;
        v.m1Req = m1Req; v.m1Wr = m1Wr; v.m1Addr = m1Addr; v.m1Wdata = m1Wdata;
        v.fxQ = fxQ;
        v.expOut = {21'd0, eWr, eRd, eWaddr, eRaddr, eData, eAck0, eAck1, eRd0, eRd1, eBusy, eGnt};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        m0_req = v.m0Req; m0_wr = v.m0Wr; m0_addr = v.m0Addr; m0_wdata = v.m0Wdata;
        m1_req = v.m1Req; m1_wr = v.m1Wr; m1_addr = v.m1Addr; m1_wdata = v.m1Wdata;
        fx_q = v.fxQ;
    endtask

    task automatic doReset();
        @(negedge clk_sys);
        rst = 1'b1;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; fx_q = 0;
        t3Req = 0; t3Wr = 0; t3Addr = 0; t3Wdata = 0; t3FxQ = 0;
        t3M1Req = 0; t3M1Wr = 0; t3M1Addr = 0; t3M1Wdata = 0;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
    endtask

    // RD_LAT=3 read on dut3: capVal is driven only in the sampling cycle, otherVal elsewhere.
    task automatic read3(input string tag, input logic [21:0] addr, input logic [7:0] otherVal,
                         input logic [7:0] capVal, input logic [7:0] expRdata);
        @(negedge clk_sys);
        t3Req = 1'b1; t3Wr = 1'b0; t3Addr = addr; t3FxQ = otherVal;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_sys);
            t3FxQ = (k == 4) ? capVal : otherVal;
            checkOutput($sformatf("lat3_%s_c%0d", tag, k), {30'd0, t3FxRd, t3M0Ack},
                        (k == 1) ? 96'd2 : ((k == 5) ? 96'd1 : 96'd0));
            if (k == 5) begin
                checkOutput($sformatf("lat3_%s_rdata", tag), {88'd0, t3M0Rdata}, {88'd0, expRdata});
                t3Req = 1'b0;
            end
        end
    endtask

    function automatic int expOrderAt(input int k);
`ifdef FX_ARB_RR_EN
        return k % 2;
`else
        return 0 * k;
`endif
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;

        vecs[0]  = mkVec(0,0,22'h0,8'h0,       1,1,22'h010020,8'hA5, 8'h00, 0,0,22'h0,22'h0,8'h00,0,0,8'h00,8'h00,0,2'b00);
        vecs[1]  = mkVec(0,0,22'h0,8'h0,       1,1,22'h010020,8'hA5, 8'h00, 1,0,22'h010020,22'h0,8'hA5,0,0,8'h00,8'h00,1,2'b10);
        vecs[2]  = mkVec(0,0,22'h0,8'h0,       1,1,22'h010020,8'hA5, 8'h00, 0,0,22'h010020,22'h0,8'hA5,0,1,8'h00,8'h00,1,2'b10);
        vecs[3]  = mkVec(0,0,22'h0,8'h0,       0,0,22'h0,8'h0,       8'h00, 0,0,22'h010020,22'h0,8'hA5,0,0,8'h00,8'h00,0,2'b00);
        vecs[4]  = mkVec(1,0,22'h010023,8'h0,  0,0,22'h0,8'h0,       8'h00, 0,0,22'h010020,22'h0,8'hA5,0,0,8'h00,8'h00,0,2'b00);
        vecs[5]  = mkVec(1,0,22'h010023,8'h0,  0,0,22'h0,8'h0,       8'h00, 0,1,22'h010020,22'h010023,8'hA5,0,0,8'h00,8'h00,1,2'b01);
        vecs[6]  = mkVec(1,0,22'h010023,8'h0,  0,0,22'h0,8'h0,       8'h80, 0,0,22'h010020,22'h010023,8'hA5,0,0,8'h00,8'h00,1,2'b01);
        vecs[7]  = mkVec(1,0,22'h010023,8'h0,  0,0,22'h0,8'h0,       8'h00, 0,0,22'h010020,22'h010023,8'hA5,1,0,8'h80,8'h00,1,2'b01);
        vecs[8]  = mkVec(0,0,22'h0,8'h0,       0,0,22'h0,8'h0,       8'h00, 0,0,22'h010020,22'h010023,8'hA5,0,0,8'h80,8'h00,0,2'b00);
        vecs[9]  = mkVec(1,1,22'h000001,8'h11, 0,0,22'h0,8'h0,       8'h00, 0,0,22'h010020,22'h010023,8'hA5,0,0,8'h80,8'h00,0,2'b00);
        vecs[10] = mkVec(1,1,22'h000001,8'h11, 0,0,22'h0,8'h0,       8'h00, 1,0,22'h000001,22'h010023,8'h11,0,0,8'h80,8'h00,1,2'b01);
        vecs[11] = mkVec(1,1,22'h000001,8'h11, 0,0,22'h0,8'h0,       8'h00, 0,0,22'h000001,22'h010023,8'h11,1,0,8'h80,8'h00,1,2'b01);
        vecs[12] = mkVec(0,0,22'h0,8'h0,       0,0,22'h0,8'h0,       8'h00, 0,0,22'h000001,22'h010023,8'h11,0,0,8'h80,8'h00,0,2'b00);

        doReset();
        checkOutput("reset_state", actualOut(), 96'd0);
        checkOutput("reset_state_lat3", {21'd0, t3FxWr, t3FxRd, t3Waddr, t3Raddr, t3Data, t3M0Ack,
                    t3M1Ack, t3M0Rdata, t3M1Rdata, t3Busy, t3Gnt}, 96'd0);

        // m1 write, then m0 read with rdata held across a later m0 write
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_sys);
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), actualOut(), vecs[i].expOut);
        end

        // Both requesters held high continuously: service order depends on the policy
        doReset();
        @(negedge clk_sys);
        m0_req = 1; m0_wr = 0; m0_addr = 22'h000100;
        m1_req = 1; m1_wr = 1; m1_addr = 22'h000200; m1_wdata = 8'h3C;
`ifdef FX_ARB_RR_EN
        nWant = 4;
`else
        nWant = 3;
`endif
        order.delete();
        budget = 0;
        while (order.size() < nWant && budget < 100) begin
            if (m0_ack) order.push_back(0);
            if (m1_ack) order.push_back(1);
            if (order.size() < nWant) begin
                @(negedge clk_sys);
                budget++;
            end
        end
        checkOutput("order_count", order.size(), nWant);
        for (int k = 0; k < order.size() && k < nWant; k++)
            checkOutput($sformatf("order%0d", k), order[k], expOrderAt(k));
        m0_req = 0; m1_req = 0;

        // Reset during WAIT of an m0 read while m1 is pending
        doReset();
        @(negedge clk_sys);
        m0_req = 1; m0_wr = 0; m0_addr = 22'h0A0001;
        m1_req = 1; m1_wr = 1; m1_addr = 22'h0B0002; m1_wdata = 8'h77;
        @(negedge clk_sys);
        checkOutput("t4_issue", {93'd0, fx_rd, gnt}, 96'b101);
        @(negedge clk_sys);
        checkOutput("t4_wait", {92'd0, busy, gnt, m0_ack}, 96'b1010);
        rst = 1'b1;
        @(negedge clk_sys);
        checkOutput("t4_reset_outputs", actualOut(), 96'd0);
        rst = 1'b0;
        m0_req = 0;
        @(negedge clk_sys);
        checkOutput("t4_m1_grant", {63'd0, gnt, fx_wr, fx_waddr, fx_data}, {63'd0, 2'b10, 1'b1, 22'h0B0002, 8'h77});
        @(negedge clk_sys);
        checkOutput("t4_m1_ack", {94'd0, m1_ack, m0_ack}, 96'b10);
        m1_req = 0;

        // RD_LAT=3: sampling-cycle read, then an unmapped read returning zero
        read3("mapped", 22'h010023, 8'hC3, 8'h5A, 8'h5A);
        read3("unmapped", 22'h3F1234, 8'h00, 8'h00, 8'h00);

        // Randomized traffic against the transaction-level model
        doReset();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pWr[p] = 0; pAddr[p] = 0; pData[p] = 0;
            issued[p] = 0; dutAcks[p] = 0; justAcked[p] = 0;
        end
        issuedTotal = 0; doneCount = 0; cyc = 0; freeCyc = 0;
        mBusy = 0; mOwner = 0; lastServed = 1; tWr = 0; tAddr = 0; tData = 0; capData = 0;
        sCyc = -1; aCyc = -1; capCyc = -1;
        while (doneCount < NTXN && cyc < 20000) begin
            @(negedge clk_sys);
            cyc++;
            inRange = mBusy && cyc >= sCyc && cyc <= aCyc;
            expGnt  = inRange ? (mOwner == 1 ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("rnd_strobe", {94'd0, fx_wr, fx_rd},
                        {94'd0, mBusy && tWr && cyc == sCyc, mBusy && !tWr && cyc == sCyc});
            checkOutput("rnd_excl", {95'd0, fx_wr & fx_rd}, 96'd0);
            checkOutput("rnd_gnt_onehot", {95'd0, $onehot0(gnt)}, 96'd1);
            checkOutput("rnd_gnt", {94'd0, gnt}, {94'd0, expGnt});
            checkOutput("rnd_busy", {95'd0, busy}, {95'd0, inRange});
            checkOutput("rnd_ack", {94'd0, m1_ack, m0_ack},
                        {94'd0, (mBusy && cyc == aCyc) ? expGnt : 2'b00});
            if (m0_ack) dutAcks[0]++;
            if (m1_ack) dutAcks[1]++;
            if (mBusy && cyc == sCyc) begin
                if (tWr) checkOutput("rnd_waddr", {66'd0, fx_waddr, fx_data}, {66'd0, tAddr, tData});
                else     checkOutput("rnd_raddr", {74'd0, fx_raddr}, {74'd0, tAddr});
            end
            if (mBusy && cyc == aCyc && !tWr)
                checkOutput("rnd_rdata", {88'd0, (mOwner == 1) ? m1_rdata : m0_rdata}, {88'd0, capData});

            justAcked[0] = 0; justAcked[1] = 0;
            if (mBusy && cyc == aCyc) begin
                pend[mOwner] = 0;
                justAcked[mOwner] = 1;
                lastServed = mOwner;
                mBusy = 0;
                freeCyc = cyc + 1;
                doneCount++;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !justAcked[p] && issuedTotal < NTXN && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1;
                    pWr[p]   = 1'($urandom_range(0, 1));
                    pAddr[p] = 22'($urandom);
                    pData[p] = 8'($urandom);
                    issued[p]++;
                    issuedTotal++;
                end
            end
            m0_req = pend[0]; m0_wr = pWr[0]; m0_addr = pAddr[0]; m0_wdata = pData[0];
            m1_req = pend[1]; m1_wr = pWr[1]; m1_addr = pAddr[1]; m1_wdata = pData[1];
            fx_q = 8'($urandom);
            if (mBusy && cyc == capCyc) capData = fx_q;

            if (!mBusy && cyc >= freeCyc && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) begin
`ifdef FX_ARB_RR_EN
                    mOwner = (lastServed == 1) ? 0 : 1;
`else
                    mOwner = 0;
`endif
                end else begin
                    mOwner = pend[1] ? 1 : 0;
                end
                mBusy  = 1;
                tWr    = pWr[mOwner];
                tAddr  = pAddr[mOwner];
                tData  = pData[mOwner];
                sCyc   = cyc + 1;
                aCyc   = tWr ? cyc + 2 : cyc + 2 + RD_LAT;
                capCyc = cyc + 1 + RD_LAT;
            end
        end
        checkOutput("rnd_completed", doneCount, NTXN);
        repeat (10) begin
            @(negedge clk_sys);
            checkOutput("rnd_tail_ack", {94'd0, m1_ack, m0_ack}, 96'd0);
        end
        checkOutput("rnd_acks_m0", dutAcks[0], issued[0]);
        checkOutput("rnd_acks_m1", dutAcks[1], issued[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
